// File: rtl/trajectory_logger_pkg.sv
// Shared definitions for the trajectory logger: heading encoding and the
// layout of the event record {remover,avancar,girar,orientacao,pos_x,pos_y}.
package trajectory_logger_pkg;

    localparam logic [2:0] ORI_N = 3'd0;
    localparam logic [2:0] ORI_E = 3'd1;
    localparam logic [2:0] ORI_S = 3'd2;
    localparam logic [2:0] ORI_W = 3'd3;

    // Bit indices inside the 3-bit flag field at the top of the record.
    localparam int REC_GIR = 0;
    localparam int REC_AV  = 1;
    localparam int REC_REM = 2;

    localparam int REC_FLAGS_W = 3;
    localparam int REC_ORI_W   = 3;

    function automatic int recPosYLsb(input int coordW);
        recPosYLsb = 0 * coordW;
    endfunction

    function automatic int recPosXLsb(input int coordW);
        recPosXLsb = coordW;
    endfunction

    function automatic int recOriLsb(input int coordW);
        recOriLsb = 2 * coordW;
    endfunction

    function automatic int recFlagLsb(input int coordW);
        recFlagLsb = 2 * coordW + REC_ORI_W;
    endfunction

endpackage

// File: rtl/trajectory_logger_fifo.sv
// Show-ahead synchronous FIFO; an empty FIFO presents all-zero data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      countReg;
    logic             doPush;
    logic             doPop;

    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts.
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    assign full  = (countReg == (AW+1)'(DEPTH));
    assign empty = (countReg == '0);
    assign count = countReg;
    assign dout  = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/trajectory_logger.sv
// Tracks grid position and removals from the robot strobes and logs every
// movement/turn/removal event into a FIFO drained over a valid/ready port.
module trajectory_logger
    import trajectory_logger_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int MAP_MAX = 15,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   avancar,
    input  logic                   girar,
    input  logic                   remover,
    input  logic [2:0]             orientacao,
    output logic [6+2*COORD_W-1:0] evt_data,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [COORD_W-1:0]     pos_x,
    output logic [COORD_W-1:0]     pos_y,
    output logic [CNT_W-1:0]       remove_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   err_edge,
    output logic                   err_orient
);

    localparam int REC_W    = 6 + 2 * COORD_W;
    localparam int POSY_LSB = recPosYLsb(COORD_W);
    localparam int POSX_LSB = recPosXLsb(COORD_W);
    localparam int ORI_LSB  = recOriLsb(COORD_W);
    localparam int FLAG_LSB = recFlagLsb(COORD_W);

    localparam logic [COORD_W-1:0] MAX_C    = COORD_W'(MAP_MAX);
    localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);

    logic                  avHist;
    logic                  girHist;
    logic                  remHist;
    logic                  avRise;
    logic                  girRise;
    logic                  remRise;
    logic                  fire;
    logic [COORD_W-1:0]    nextX;
    logic [COORD_W-1:0]    nextY;
    logic                  edgeHit;
    logic                  orientBad;
    logic [REC_FLAGS_W-1:0] flags;
    logic [REC_W-1:0]      record;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  fifoPop;
    logic                  dropped;
    logic [$clog2(DEPTH):0] fifoCount;

    assign avRise  = avancar & ~avHist;
    assign girRise = girar & ~girHist;
    assign remRise = remover & ~remHist;
    assign fire    = avRise | girRise | remRise;

    assign fifoPop   = evt_ready & ~fifoEmpty;
    assign dropped   = fire & fifoFull & ~fifoPop;
    assign evt_valid = (fifoCount != '0);

    // Blocked moves hold position; the record always carries the post-update position.
    always_comb begin
        nextX     = pos_x;
        nextY     = pos_y;
        edgeHit   = 1'b0;
        orientBad = 1'b0;
        if (avRise) begin
            case (orientacao)
                ORI_N: if (pos_y == MAX_C) edgeHit = 1'b1; else nextY = pos_y + 1'b1;
                ORI_E: if (pos_x == MAX_C) edgeHit = 1'b1; else nextX = pos_x + 1'b1;
                ORI_S: if (pos_y == '0)    edgeHit = 1'b1; else nextY = pos_y - 1'b1;
                ORI_W: if (pos_x == '0)    edgeHit = 1'b1; else nextX = pos_x - 1'b1;
                default: orientBad = 1'b1;
            endcase
        end

        flags          = '0;
        flags[REC_REM] = remRise;
        flags[REC_AV]  = avRise;
        flags[REC_GIR] = girRise;

        record = '0;
        record[FLAG_LSB +: REC_FLAGS_W] = flags;
        record[ORI_LSB  +: REC_ORI_W]   = orientacao;
        record[POSX_LSB +: COORD_W]     = nextX;
        record[POSY_LSB +: COORD_W]     = nextY;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            avHist       <= 1'b0;
            girHist      <= 1'b0;
            remHist      <= 1'b0;
            pos_x        <= START_XC;
            pos_y        <= START_YC;
            remove_count <= '0;
            drop_count   <= '0;
            err_edge     <= 1'b0;
            err_orient   <= 1'b0;
        end else begin
            avHist  <= avancar;
            girHist <= girar;
            remHist <= remover;
            pos_x   <= nextX;
            pos_y   <= nextY;
            if (edgeHit) begin
                err_edge <= 1'b1;
            end
            if (orientBad) begin
                err_orient <= 1'b1;
            end
            if (remRise && (remove_count != '1)) begin
                remove_count <= remove_count + 1'b1;
            end
            if (dropped && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) eventFifo (
        .clock (clock),
        .reset (reset),
        .push  (fire),
        .pop   (fifoPop),
        .din   (record),
        .dout  (evt_data),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

endmodule

// File: tb/tb_trajectory_logger.sv
// Bench for trajectory_logger: directed scenarios plus randomized strobes,
// all outputs compared each cycle against a queue-based reference model.
module tb_trajectory_logger;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        avancar = 1'b0;
    logic        girar = 1'b0;
    logic        remover = 1'b0;
    logic [2:0]  orientacao = 3'd0;
    logic        evt_ready = 1'b0;
    logic [13:0] evt_data;
    logic        evt_valid;
    logic [3:0]  pos_x;
    logic [3:0]  pos_y;
    logic [7:0]  remove_count;
    logic [7:0]  drop_count;
    logic        err_edge;
    logic        err_orient;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          mX, mY, mRem, mDrop;
    bit          mEdge, mOrient;
    bit          prevAv, prevGir, prevRem;
    logic [13:0] mQueue[$];

    trajectory_logger dut (
        .clock        (clock),
        .reset        (reset),
        .avancar      (avancar),
        .girar        (girar),
        .remover      (remover),
        .orientacao   (orientacao),
        .evt_data     (evt_data),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .remove_count (remove_count),
        .drop_count   (drop_count),
        .err_edge     (err_edge),
        .err_orient   (err_orient)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic modelStep();
        bit avR, girR, remR, popping;
        int nx, ny;
        if (reset) begin
            mX = 0; mY = 0; mRem = 0; mDrop = 0;
            mEdge = 0; mOrient = 0;
            prevAv = 0; prevGir = 0; prevRem = 0;
            mQueue.delete();
            return;
        end
        avR  = avancar && !prevAv;
        girR = girar && !prevGir;
        remR = remover && !prevRem;
        nx = mX;
        ny = mY;
        if (avR) begin
            case (orientacao)
                3'd0: ny = mY + 1;
                3'd1: nx = mX + 1;
                3'd2: ny = mY - 1;
                3'd3: nx = mX - 1;
                default: mOrient = 1;
            endcase
            if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
                mEdge = 1;
                nx = mX;
                ny = mY;
            end
        end
        mX = nx;
        mY = ny;
        if (remR && mRem < 255) mRem++;
        popping = (mQueue.size() > 0) && evt_ready;
        if (popping) void'(mQueue.pop_front());
        if (avR || girR || remR) begin
            if (mQueue.size() < 8)
                mQueue.push_back({remR, avR, girR, orientacao, 4'(mX), 4'(mY)});
            else if (mDrop < 255)
                mDrop++;
        end
        prevAv = avancar;
        prevGir = girar;
        prevRem = remover;
    endtask

    task automatic compareAll();
        checkOutput("valid", evt_valid, mQueue.size() > 0);
        checkOutput("data", evt_data, (mQueue.size() > 0) ? mQueue[0] : 14'd0);
        checkOutput("pos_x", pos_x, mX);
        checkOutput("pos_y", pos_y, mY);
        checkOutput("remove_count", remove_count, mRem);
        checkOutput("drop_count", drop_count, mDrop);
        checkOutput("err_edge", err_edge, mEdge);
        checkOutput("err_orient", err_orient, mOrient);
    endtask

    // Drive one cycle of inputs, let the edge happen, then check at the falling edge.
    task automatic applyStimulus(input logic rst, input logic av, input logic gi,
                                 input logic re, input logic [2:0] ori, input logic rdy);
        reset = rst;
        avancar = av;
        girar = gi;
        remover = re;
        orientacao = ori;
        evt_ready = rdy;
        modelStep();
        @(posedge clock);
        @(negedge clock);
        compareAll();
    endtask

    initial begin
        @(negedge clock);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst_valid", evt_valid, 0);
        checkOutput("rst_data", evt_data, 0);
        checkOutput("rst_pos", {pos_x, pos_y}, 0);

        // Held advance east: exactly one move and one record
        applyStimulus(0, 1, 0, 0, 3'd1, 1);
        checkOutput("t1_valid", evt_valid, 1);
        checkOutput("t1_data", evt_data, {3'b010, 3'd1, 4'd1, 4'd0});
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 3'd1, 1);
        checkOutput("t1_pos_x", pos_x, 1);
        checkOutput("t1_pos_y", pos_y, 0);

        // West back to 0, then west again is blocked at the edge
        applyStimulus(0, 0, 0, 0, 3'd3, 1);
        applyStimulus(0, 1, 0, 0, 3'd3, 1);
        applyStimulus(0, 0, 0, 0, 3'd3, 1);
        applyStimulus(0, 1, 0, 0, 3'd3, 1);
        checkOutput("t2_pos_x", pos_x, 0);
        checkOutput("t2_err_edge", err_edge, 1);
        checkOutput("t2_data", evt_data, {3'b010, 3'd3, 4'd0, 4'd0});

        applyStimulus(0, 0, 0, 0, 3'd5, 1);
        applyStimulus(0, 1, 0, 0, 3'd5, 1);
        checkOutput("t3_err_orient", err_orient, 1);
        checkOutput("t3_data", evt_data, {3'b010, 3'd5, 4'd0, 4'd0});
        checkOutput("t3_err_edge", err_edge, 1);

        applyStimulus(0, 0, 0, 0, 3'd0, 1);
        applyStimulus(0, 1, 0, 1, 3'd0, 1);
        checkOutput("t4_data", evt_data, {3'b110, 3'd0, 4'd0, 4'd1});
        checkOutput("t4_remove", remove_count, 1);
        applyStimulus(0, 0, 0, 0, 3'd0, 1);
        applyStimulus(0, 0, 0, 0, 3'd0, 1);

        // Ten turns into a stalled consumer: eight kept, two dropped
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, 0, 3'(i % 8), 0);
            applyStimulus(0, 0, 0, 0, 3'(i % 8), 0);
        end
        checkOutput("t5_drop", drop_count, 2);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t5_drain_valid", evt_valid, 1);
            checkOutput("t5_drain_ori", evt_data[10:8], i);
            applyStimulus(0, 0, 0, 0, 3'd0, 1);
        end
        checkOutput("t5_empty", evt_valid, 0);

        // Full FIFO with a simultaneous pop accepts the new record
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 0, 3'(i), 0);
            applyStimulus(0, 0, 0, 0, 3'(i), 0);
        end
        applyStimulus(0, 0, 1, 0, 3'd6, 1);
        checkOutput("t6_drop", drop_count, 2);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 3'd0, 1);
        applyStimulus(1, 0, 0, 0, 3'd0, 1);
        checkOutput("t6_rst_valid", evt_valid, 0);
        checkOutput("t6_rst_counts", {remove_count, drop_count}, 0);
        applyStimulus(0, 0, 0, 0, 3'd0, 1);

        // Counter saturation: 270 removals and turns with no consumer
        for (int i = 0; i < 270; i++) begin
            applyStimulus(0, 0, 1, 1, 3'd0, 0);
            applyStimulus(0, 0, 0, 0, 3'd0, 0);
        end
        checkOutput("sat_remove", remove_count, 255);
        checkOutput("sat_drop", drop_count, 255);
        applyStimulus(1, 0, 0, 0, 3'd0, 0);

        // Randomized strobes, headings, backpressure and occasional reset
        for (int i = 0; i < 2000; i++) begin
            logic av, gi, re;
            av = ($urandom_range(0, 9) < 3) ? ~avancar : avancar;
            gi = ($urandom_range(0, 9) < 2) ? ~girar : girar;
            re = ($urandom_range(0, 9) < 2) ? ~remover : remover;
            applyStimulus($urandom_range(0, 399) == 0, av, gi, re,
                          3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
